// File: rtl/uart_fifo_phy.sv
// UART byte PHY: TX FIFO feeding an 8N1-style serialiser, and an oversampled
// deserialiser feeding an RX FIFO. Both FIFOs are first-word-fall-through.

module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  // Gating by full/empty alone gives the push-only-when-empty and
  // pop-only-when-full behaviour for simultaneous requests.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module uart_fifo_phy #(
  parameter int CLK_HZ       = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  output logic                    uart_txd,
  input  logic                    tx_write,
  input  logic [PAYLOAD_BITS-1:0] tx_write_data,
  output logic                    tx_full,
  output logic                    tx_empty,
  output logic                    tx_busy,
  input  logic                    rx_read,
  output logic [PAYLOAD_BITS-1:0] rx_read_data,
  output logic                    rx_full,
  output logic                    rx_empty,
  output logic                    rx_break
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_HOLD} rx_state_t;

  tx_state_t               tx_state, tx_state_next;
  logic [CW-1:0]           tx_cnt, tx_cnt_next;
  logic [BW-1:0]           tx_bit, tx_bit_next;
  logic [PAYLOAD_BITS-1:0] tx_shift, tx_shift_next, tx_head;
  logic                    tx_pop, txd_next;

  rx_state_t               rx_state, rx_state_next;
  logic [CW-1:0]           rx_cnt, rx_cnt_next;
  logic [BW-1:0]           rx_bit, rx_bit_next;
  logic [PAYLOAD_BITS-1:0] rx_shift, rx_shift_next;
  logic [1:0]              rx_sync;
  logic                    rxd_s, rx_push, break_det;

  uart_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(DEPTH)) tx_fifo (
    .clk(clk), .reset(reset), .push(tx_write), .push_data(tx_write_data),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(DEPTH)) rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_shift),
    .pop(rx_read), .head(rx_read_data), .full(rx_full), .empty(rx_empty)
  );

  assign tx_busy = (tx_state != TX_IDLE);

  always_comb begin
    tx_state_next = tx_state;
    tx_cnt_next   = tx_cnt + CW'(1);
    tx_bit_next   = tx_bit;
    tx_shift_next = tx_shift;
    tx_pop        = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_next = '0;
        if (!tx_empty) begin
          tx_pop        = 1'b1;
          tx_shift_next = tx_head;
          tx_state_next = TX_START;
        end
      end
      TX_START: if (tx_cnt == BIT_END) begin
        tx_cnt_next   = '0;
        tx_bit_next   = '0;
        tx_state_next = TX_DATA;
      end
      TX_DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_next   = '0;
        tx_shift_next = tx_shift >> 1;
        tx_bit_next   = tx_bit + BW'(1);
        if (tx_bit == LAST_BIT) tx_state_next = TX_STOP;
      end
      TX_STOP: if (tx_cnt == BIT_END) begin
        tx_cnt_next   = '0;
        tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
    // Line level follows the state being entered so uart_txd can be a flop.
    case (tx_state_next)
      TX_START: txd_next = 1'b0;
      TX_DATA:  txd_next = tx_shift_next[0];
      default:  txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx_cnt   <= tx_cnt_next;
      tx_bit   <= tx_bit_next;
      uart_txd <= txd_next;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_next;
    rx_shift <= rx_shift_next;
  end

  assign rxd_s = rx_sync[1];

  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_next   = rx_cnt + CW'(1);
    rx_bit_next   = rx_bit;
    rx_shift_next = rx_shift;
    rx_push       = 1'b0;
    break_det     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (!rxd_s) rx_state_next = RX_START;
      end
      RX_START: if (rx_cnt == HALF_END) begin
        rx_cnt_next   = '0;
        rx_bit_next   = '0;
        rx_state_next = rxd_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_next   = '0;
        rx_shift_next = {rxd_s, rx_shift[PAYLOAD_BITS-1:1]};
        rx_bit_next   = rx_bit + BW'(1);
        if (rx_bit == LAST_BIT) rx_state_next = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_END) begin
        rx_cnt_next = '0;
        if (rxd_s) begin
          rx_push       = 1'b1;
          rx_state_next = RX_IDLE;
        end else begin
          // All-zero payload with a low stop bit is a break; otherwise a framing error.
          break_det     = (rx_shift == '0);
          rx_state_next = RX_HOLD;
        end
      end
      RX_HOLD: begin
        rx_cnt_next = '0;
        if (rxd_s) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync  <= 2'b11;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_break <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rxd};
      rx_state <= rx_state_next;
      rx_cnt   <= rx_cnt_next;
      rx_bit   <= rx_bit_next;
      rx_break <= break_det;
    end
  end
endmodule

// File: tb/tb_uart_fifo_phy.sv
// Self-checking bench for uart_fifo_phy at CPB=10, DEPTH=4, with optional loopback.

module tb_uart_fifo_phy;
  localparam int CPB   = 10;
  localparam int PB    = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rxd_drv = 1'b1;
  logic         loop_en = 1'b0;
  logic         uart_rxd, uart_txd;
  logic         tx_write = 1'b0;
  logic [PB-1:0] tx_write_data = '0;
  logic         tx_full, tx_empty, tx_busy;
  logic         rx_read = 1'b0;
  logic [PB-1:0] rx_read_data;
  logic         rx_full, rx_empty, rx_break;

  int checks = 0;
  int errors = 0;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  uart_fifo_phy #(.CLK_HZ(100), .BIT_RATE(10), .PAYLOAD_BITS(PB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .tx_write(tx_write), .tx_write_data(tx_write_data), .tx_full(tx_full),
    .tx_empty(tx_empty), .tx_busy(tx_busy), .rx_read(rx_read),
    .rx_read_data(rx_read_data), .rx_full(rx_full), .rx_empty(rx_empty),
    .rx_break(rx_break)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench-side UART transmitter onto rxd_drv: start, LSB-first data, stop.
  task automatic send_frame(input logic [PB-1:0] b);
    rxd_drv = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < PB; i++) begin
      rxd_drv = b[i];
      repeat (CPB) tick();
    end
    rxd_drv = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
    checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_tx_empty: got %b want 1", tx_empty); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
    checks++; if (rx_full !== 1'b0) begin errors++; $display("FAIL reset_rx_full: got %b want 0", rx_full); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    checks++; if (rx_break !== 1'b0) begin errors++; $display("FAIL reset_rx_break: got %b want 0", rx_break); end
    checks++; if (rx_read_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_read_data); end
    reset = 1'b0;
    repeat (2) tick();
    checks++; if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: txd=%b busy=%b want 1/0", uart_txd, tx_busy);
    end
  endtask

  // Expected line for sample k after the start edge is derived from the frame layout.
  task automatic test_tx(input logic [PB-1:0] b);
    int slot;
    logic exp;
    loop_en = 1'b0;
    tx_write = 1'b1; tx_write_data = b;
    tick();
    tx_write = 1'b0;
    checks++; if (tx_empty !== 1'b0) begin errors++; $display("FAIL tx_empty_after_write: got %b want 0", tx_empty); end
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL tx_line_before_start: got %b want 1", uart_txd); end
    for (int k = 0; k < (PB + 2) * CPB; k++) begin
      tick();
      slot = k / CPB;
      if (slot == 0) exp = 1'b0;
      else if (slot == PB + 1) exp = 1'b1;
      else exp = b[slot-1];
      checks++; if (uart_txd !== exp) begin
        errors++; $display("FAIL tx_bit byte=%h cycle=%0d: got %b want %b", b, k, uart_txd, exp);
      end
      checks++; if (tx_busy !== 1'b1) begin
        errors++; $display("FAIL tx_busy byte=%h cycle=%0d: got %b want 1", b, k, tx_busy);
      end
    end
    tick();
    checks++; if (tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
      errors++; $display("FAIL tx_end byte=%h: busy=%b txd=%b want 0/1", b, tx_busy, uart_txd);
    end
  endtask

  task automatic test_loopback();
    int gap = 0, falls = 0, cyc = 0;
    bit seen = 0, prev = 0, got_first = 0, gap_line_ok = 1;
    logic [PB-1:0] first_head = '0;
    loop_en = 1'b1;
    tx_write = 1'b1; tx_write_data = 8'h3C; tick();
    tx_write_data = 8'hC3; tick();
    tx_write = 1'b0;
    while (falls < 2 && cyc < 1000) begin
      tick(); cyc++;
      if (!got_first && !rx_empty) begin got_first = 1; first_head = rx_read_data; end
      if (prev && !tx_busy) falls++;
      if (tx_busy) seen = 1;
      else if (seen && falls < 2) begin gap++; if (uart_txd !== 1'b1) gap_line_ok = 0; end
      prev = tx_busy;
    end
    checks++; if (falls != 2) begin errors++; $display("FAIL loop_timeout: frames seen %0d want 2", falls); end
    checks++; if (gap != 1) begin errors++; $display("FAIL loop_gap: got %0d cycles want 1", gap); end
    checks++; if (!gap_line_ok) begin errors++; $display("FAIL loop_gap_line: got low want high"); end
    checks++; if (first_head !== 8'h3C) begin errors++; $display("FAIL loop_first: got %h want 3c", first_head); end
    repeat (20) tick();
    checks++; if (rx_read_data !== 8'h3C) begin errors++; $display("FAIL loop_head0: got %h want 3c", rx_read_data); end
    rx_read = 1'b1; tick(); rx_read = 1'b0;
    checks++; if (rx_read_data !== 8'hC3) begin errors++; $display("FAIL loop_head1: got %h want c3", rx_read_data); end
    rx_read = 1'b1; tick(); rx_read = 1'b0;
    checks++; if (rx_empty !== 1'b1 || rx_read_data !== 8'h00) begin
      errors++; $display("FAIL loop_drained: empty=%b data=%h want 1/00", rx_empty, rx_read_data);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_loopback_random();
    logic [PB-1:0] q[$];
    logic [PB-1:0] exp;
    int n, cyc;
    loop_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        tx_write = 1'b1;
        tx_write_data = 8'($urandom);
        q.push_back(tx_write_data);
        tick();
      end
      tx_write = 1'b0;
      cyc = 0;
      while (q.size() > 0 && cyc < (n + 1) * (PB + 2) * CPB + 100) begin
        tick(); cyc++;
        if (!rx_empty) begin
          exp = q.pop_front();
          checks++; if (rx_read_data !== exp) begin
            errors++; $display("FAIL rand_loop round=%0d: got %h want %h", r, rx_read_data, exp);
          end
          rx_read = 1'b1; tick(); rx_read = 1'b0;
        end
      end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_loop_timeout: %0d bytes missing want 0", q.size()); q.delete(); end
      repeat (20) tick();
    end
    loop_en = 1'b0;
  endtask

  task automatic test_rx_overflow();
    logic [PB-1:0] q[$];
    logic [PB-1:0] exp;
    loop_en = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v));
      if (q.size() < DEPTH) q.push_back(8'(v));
    end
    repeat (5) tick();
    checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", rx_full); end
    while (q.size() > 0) begin
      exp = q.pop_front();
      checks++; if (rx_read_data !== exp) begin errors++; $display("FAIL ovf_pop: got %h want %h", rx_read_data, exp); end
      rx_read = 1'b1; tick(); rx_read = 1'b0;
    end
    checks++; if (rx_empty !== 1'b1 || rx_full !== 1'b0) begin
      errors++; $display("FAIL ovf_after: empty=%b full=%b want 1/0", rx_empty, rx_full);
    end
  endtask

  task automatic test_break();
    int pulses = 0;
    loop_en = 1'b0;
    rxd_drv = 1'b0;
    repeat (12 * CPB) begin tick(); if (rx_break === 1'b1) pulses++; end
    rxd_drv = 1'b1;
    repeat (3 * CPB) begin tick(); if (rx_break === 1'b1) pulses++; end
    checks++; if (pulses != 1) begin errors++; $display("FAIL break_pulse: got %0d high cycles want 1", pulses); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL break_fifo: empty=%b want 1", rx_empty); end
    send_frame(8'h55);
    repeat (5) tick();
    checks++; if (rx_empty !== 1'b0 || rx_read_data !== 8'h55) begin
      errors++; $display("FAIL break_next: empty=%b data=%h want 0/55", rx_empty, rx_read_data);
    end
    rx_read = 1'b1; tick(); rx_read = 1'b0;
  endtask

  task automatic test_fifo_corners();
    logic [PB-1:0] v[7];
    logic [PB-1:0] got[$];
    int cyc;
    for (int i = 0; i < 7; i++) v[i] = 8'($urandom);
    loop_en = 1'b1;
    rx_read = 1'b1; tick(); rx_read = 1'b0;
    checks++; if (rx_empty !== 1'b1 || rx_read_data !== 8'h00) begin
      errors++; $display("FAIL pop_empty: empty=%b data=%h want 1/00", rx_empty, rx_read_data);
    end
    for (int i = 0; i < 3; i++) begin tx_write = 1'b1; tx_write_data = v[i]; tick(); end
    tx_write = 1'b0;
    cyc = 0;
    while (tx_busy && cyc < 500) begin
      if (!rx_empty) got.push_back(rx_read_data);
      rx_read = !rx_empty;
      tick(); rx_read = 1'b0; cyc++;
    end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL corner_idle_timeout: busy=%b want 0", tx_busy); end
    // Serialiser is in its IDLE cycle with two queued bytes: this write coincides with its pop.
    tx_write = 1'b1; tx_write_data = v[3]; tick();
    tx_write_data = v[4]; tick();
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL corner_count3: full=%b want 0", tx_full); end
    tx_write_data = v[5]; tick();
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL corner_count4: full=%b want 1", tx_full); end
    tx_write_data = v[6]; tick();
    tx_write = 1'b0;
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL corner_full_hold: full=%b want 1", tx_full); end
    cyc = 0;
    while (got.size() < 6 && cyc < 1200) begin
      if (!rx_empty) got.push_back(rx_read_data);
      rx_read = !rx_empty;
      tick(); rx_read = 1'b0; cyc++;
    end
    repeat (3 * CPB) tick();
    checks++; if (got.size() != 6 || rx_empty !== 1'b1) begin
      errors++; $display("FAIL corner_count: got %0d bytes empty=%b want 6/1", got.size(), rx_empty);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] !== v[i]) begin errors++; $display("FAIL corner_order idx=%0d: got %h want %h", i, got[i], v[i]); end
      end
    end
    loop_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int low_cycles = 0;
    loop_en = 1'b0;
    send_frame(8'h81);
    tx_write = 1'b1; tx_write_data = 8'h0F; tick();
    tx_write_data = 8'hF0; tick();
    tx_write = 1'b0;
    rxd_drv = 1'b0;
    repeat (35) tick();
    checks++; if (tx_busy !== 1'b1 || rx_empty !== 1'b0) begin
      errors++; $display("FAIL midframe_setup: busy=%b rx_empty=%b want 1/0", tx_busy, rx_empty);
    end
    reset = 1'b1; tick();
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL midreset_txd: got %b want 1", uart_txd); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", tx_busy); end
    checks++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1) begin
      errors++; $display("FAIL midreset_fifos: tx_empty=%b rx_empty=%b want 1/1", tx_empty, rx_empty);
    end
    reset = 1'b0; rxd_drv = 1'b1;
    repeat (150) begin tick(); if (uart_txd !== 1'b1) low_cycles++; end
    checks++; if (low_cycles != 0) begin errors++; $display("FAIL midreset_line: got %0d low cycles want 0", low_cycles); end
    checks++; if (rx_empty !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL midreset_after: rx_empty=%b busy=%b want 1/0", rx_empty, tx_busy);
    end
  endtask

  initial begin
    test_reset();
    test_tx(8'hA5);
    test_tx(8'($urandom));
    test_tx(8'($urandom));
    test_loopback();
    test_loopback_random();
    test_rx_overflow();
    test_break();
    test_fifo_corners();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_fifo_phy.md
# uart_fifo_phy

Byte-level UART physical layer with a transmit FIFO and a receive FIFO. It serialises bytes written into the TX FIFO onto `uart_txd` and deserialises frames from `uart_rxd` into the RX FIFO. It sits below the memory-mapped UART register block, which only pushes and pops bytes through the FIFO-style ports. The frame format is 8N1-style: 1 start bit, PAYLOAD_BITS data bits LSB first, 1 stop bit, no parity.

## Interface
- CLK_HZ, 25000000, clock frequency in Hz
- BIT_RATE, 9600, baud rate; CPB = CLK_HZ/BIT_RATE (integer division), must be ≥ 4
- PAYLOAD_BITS, 8, data bits per frame
- DEPTH, 8, entries per FIFO; must be a power of two ≥ 2
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- uart_rxd  in  1  serial input, asynchronous, idle high
- uart_txd  out  1  serial output, idle high
- tx_write  in  1  push tx_write_data into the TX FIFO
- tx_write_data  in  PAYLOAD_BITS  byte to transmit
- tx_full  out  1  TX FIFO holds DEPTH entries
- tx_empty  out  1  TX FIFO holds 0 entries
- tx_busy  out  1  serialiser is mid-frame
- rx_read  in  1  pop the RX FIFO head
- rx_read_data  out  PAYLOAD_BITS  RX FIFO head (show-ahead); 0 when empty
- rx_full  out  1  RX FIFO holds DEPTH entries
- rx_empty  out  1  RX FIFO holds 0 entries
- rx_break  out  1  one-cycle pulse when a break is detected

## Operation
**FIFOs (both identical)**
- Circular buffer with read and write pointers plus an occupancy count.
- First-word-fall-through: the head entry is presented combinationally.
- Push is accepted only when not full; a push when full is dropped.
- Pop is accepted only when not empty; a pop when empty is ignored.
- Push and pop in the same cycle when neither full nor empty: both happen, count unchanged.
- Same cycle when empty: only the push happens. Same cycle when full: only the pop happens.
- Pointers wrap modulo DEPTH.

**TX serialiser** — states IDLE → START → DATA → STOP → IDLE
- IDLE: if the TX FIFO is not empty, pop the head into the shift register and go to START.
- START, DATA and STOP each last CPB cycles per bit.
- DATA shifts out bit 0 first.
- `uart_txd` is registered: 1 in IDLE and STOP, 0 in START, data bit in DATA.
- `tx_busy` = state ≠ IDLE.

**RX deserialiser** — states IDLE → START → DATA → STOP → IDLE
- Input passes through a 2-flop synchroniser.
- IDLE: a synchronised 0 starts a frame.
- START: resample at CPB/2. If the line is 1, treat it as a glitch and return to IDLE.
- DATA: sample each bit every CPB cycles from the start-bit centre, LSB first.
- STOP: sample at the stop-bit centre, then:
  - stop bit = 1: push the byte into the RX FIFO (dropped if full).
  - stop bit = 0 and all data bits 0: pulse `rx_break` and push nothing.
  - stop bit = 0 and data nonzero: framing error, discard the byte.
- After a stop bit of 0, wait for the line to return to 1 before re-entering IDLE.

## Timing
- Reset values:
  - `uart_txd`=1, `tx_busy`=0, `rx_break`=0
  - both FIFOs empty: `tx_empty`=`rx_empty`=1, `tx_full`=`rx_full`=0, `rx_read_data`=0
  - both FSMs in IDLE
- Reset mid-frame aborts both directions; `uart_txd` is 1 on the cycle after the reset edge.
- TX: `tx_write` at edge E gives `tx_empty`=0 after E. Pop and START entry happen at E+1, so `uart_txd` falls after E+1.
- Frame length is (PAYLOAD_BITS+2)·CPB cycles. Back-to-back frames are separated by exactly one IDLE cycle with the line high.
- RX: the byte is visible (`rx_empty`=0, `rx_read_data` valid) no later than 2 cycles after the stop-bit sample.
- Pop: `rx_read` at edge E advances the head, visible after E.
- `rx_break` is high for exactly one cycle per break event.

## Test plan
- Reset: CPB=10, assert reset 3 cycles → `uart_txd`=1, `tx_empty`=`rx_empty`=1, `tx_full`=`rx_full`=0, `tx_busy`=0.
- TX 0xA5, CPB=10:
  - `uart_txd` low for 10 cycles, then bits 1,0,1,0,0,1,0,1 each for 10 cycles, then high for 10.
  - `tx_busy` high for exactly 100 cycles.
- Loopback `uart_txd`→`uart_rxd`, write 0x3C then 0xC3:
  - `rx_read_data`=0x3C after the first frame; after one `rx_read`, 0xC3.
  - Line gap between frames is exactly 1 cycle.
- RX overflow, DEPTH=4: drive 5 frames 0x01..0x05 with no reads → `rx_full`=1; four pops return 0x01..0x04, then `rx_empty`=1 (0x05 dropped).
- Break: hold `rxd` low for 12 bit times → one `rx_break` pulse, RX FIFO unchanged. Next valid frame 0x55 is received correctly.
- FIFO corners:
  - Simultaneous push/pop on a FIFO holding 2 entries → count stays 2.
  - `tx_write` when `tx_full` is dropped.
  - `rx_read` when empty has no effect.
- Reset mid-frame → line high and FIFOs empty.
